alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator side of the ALU operand/select interface: buffers ALU commands, drives on/in_sel/num1/num2/out_sel
//  into the ALU datapath (main), waits a fixed latency, captures the ALU result, and returns it with a valid/ready handshake.
//  Replaces hand-timed testbench stimulus; sits between a host/command source and the ALU.
// PARAMETERS
//  DEPTH    8  command buffer entries (power of 2, >=2)
//  ALU_LAT  2  cycles from load cycle to ALU 'out' being valid (>=1)
//  DW       8  operand/result width
//  OPW      7  out_sel (operation select) width
// PORTS
//  clk          in   1          clock, all logic rising-edge
//  rst          in   1          synchronous, active-high reset
//  cmd_wr_en    in   1          push cmd_wr_data into buffer
//  cmd_wr_data  in   2*DW+OPW+DW  {expect[DW-1:0], out_sel[OPW-1:0], num2, num1}
//  cmd_full     out  1          buffer holds DEPTH entries
//  cmd_count    out  $clog2(DEPTH)+1  entries held
//  cmd_ovf      out  1          sticky: push attempted while full
//  start        in   1          begin draining buffer (ignored while busy)
//  busy         out  1          FSM not IDLE
//  done         out  1          1-cycle pulse: buffer drained, FSM returns IDLE
//  on           out  1          ALU enable
//  in_sel       out  3          {persist, load, reset} to ALU input muxes
//  num1, num2   out  DW         ALU operands
//  out_sel      out  OPW        ALU operation select
//  alu_out      in   DW         ALU result
//  res_valid    out  1          result available
//  res_ready    in   1          consumer accepts result
//  res_data     out  DW         captured alu_out
//  res_op       out  OPW        out_sel of the captured command
// BEHAVIOUR
//  Reset: all outputs 0 (on=0, in_sel=000, num1/num2/out_sel=0, res_valid=0, busy=0, done=0, cmd_ovf=0); buffer emptied; FSM IDLE.
//  Buffer: FIFO, rd/wr pointers wrap modulo DEPTH. Push when full dropped + cmd_ovf set. Push and pop same cycle allowed, count unchanged.
//  FSM (all outputs registered):
//   IDLE:    outputs idle (in_sel=000, on=0). start & count>0 -> ISSUE. start & count==0 -> done pulse next cycle, stay IDLE.
//   ISSUE:   1 cycle: on=1, in_sel=010 (load), num1/num2/out_sel from head entry. -> WAIT.
//   WAIT:    ALU_LAT cycles: on=1, in_sel=100 (persist), operands held. -> CAPTURE on last cycle.
//   CAPTURE: 1 cycle: res_data<=alu_out, res_op<=out_sel, res_valid<=1. -> HOLD.
//   HOLD:    res_valid=1 until res_valid&res_ready; then pop head; count>0 (after pop) -> ISSUE, else done pulse, -> IDLE.
//  Latency: start sampled cycle t -> in_sel=010 at t+1 -> res_valid at t+ALU_LAT+3 (earliest).
//  Back-to-back: res accepted cycle h -> next ISSUE at h+1. Pushes during busy are executed in the same run.
//  Mid-operation rst: abandons command in flight (not popped result lost), buffer cleared, outputs to reset values next edge.
//  res_data/res_op hold last value after handshake until next CAPTURE.
// CONFIGURATION
//  RESULT_CHECK_EN defined: adds ports err (out,1, 1-cycle pulse in CAPTURE+1 when alu_out != expect) and
//   mismatch_cnt (out,8, saturating at 8'hFF, cleared by rst). Not defined: expect field ignored, no err/mismatch_cnt ports.
// STRUCTURE
//  Shared package/header: in_sel encodings (IN_SEL_IDLE 000, RESET 001, LOAD 010, PERSIST 100), FSM state codes (3 bits),
//   command field offsets/widths.
//  One sub-module: alu_cmd_fifo (DEPTH x cmd width, count, full/empty, ovf); FSM + capture in top.
// TESTING
//  Stub ALU: alu_out = registered function of latched operands with ALU_LAT delay.
//  1 Reset: rst high 2 cycles mid-run -> all outputs 0, cmd_count=0, busy=0 next edge.
//  2 Single cmd num1=8'h57 num2=8'h1A out_sel=7'b0001000, stub returns 8'h71, start, res_ready=1 ->
//    in_sel=010 one cycle, 100 for ALU_LAT, res_valid with res_data=8'h71, res_op=7'b0001000, done pulse.
//  3 Backpressure: 3 cmds, res_ready=0 for 5 cycles on first -> res_valid/res_data stable, no ISSUE until accept; 3 results in order.
//  4 Full/overflow: DEPTH+1 pushes -> cmd_full=1, cmd_count=DEPTH, cmd_ovf=1, extra cmd never issued; wrap: drain then push DEPTH more, order kept.
//  5 start with empty buffer -> done pulse, busy stays 0; start while busy -> ignored, no duplicate done.
//  6 RESULT_CHECK_EN: expect=8'h71 vs stub 8'h70 -> err pulse, mismatch_cnt=1; matching cmd -> no err.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer_pkg
//  Description : Shared in_sel encodings, FSM state codes and command field
//                layout helpers for the ALU command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

    localparam logic [2:0] IN_SEL_IDLE    = 3'b000;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd4;

    // Command layout, LSB first: num1, num2, out_sel, expect.
    function automatic int cmd_width(input int dw, input int opw);
        return 3 * dw + opw;
    endfunction

    function automatic int num2_lsb(input int dw);
        return dw;
    endfunction

    function automatic int op_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int exp_lsb(input int dw, input int opw);
        return 2 * dw + opw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Command buffer with occupancy count, sticky overflow flag and
//                a peek at the entry behind the head for back-to-back issue.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             head,
    output logic [W-1:0]             head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_ptr_inc;

    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign ovf          = r_ovf;
    assign w_push       = wr_en && !full;
    assign w_pop        = rd_en && !empty;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
    assign head         = r_mem[r_rd_ptr];
    assign head_next    = r_mem[w_rd_ptr_inc];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Drains buffered ALU commands into the ALU operand/select
//                interface and returns each result over a valid/ready port.
//                Optional macro RESULT_CHECK_EN adds err/mismatch_cnt ports.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 2,
    parameter int DW      = 8,
    parameter int OPW     = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_wr_en,
    input  logic [3*DW+OPW-1:0]      cmd_wr_data,
    output logic                     cmd_full,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     cmd_ovf,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     on,
    output logic [2:0]               in_sel,
    output logic [DW-1:0]            num1,
    output logic [DW-1:0]            num2,
    output logic [OPW-1:0]           out_sel,
    input  logic [DW-1:0]            alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [OPW-1:0]           res_op
`ifdef RESULT_CHECK_EN
    ,output logic                    err
    ,output logic [7:0]              mismatch_cnt
`endif
);

    localparam int CW      = cmd_width(DW, OPW);
    localparam int N2_LSB  = num2_lsb(DW);
    localparam int OP_LSB  = op_lsb(DW);
    localparam int EX_LSB  = exp_lsb(DW, OPW);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int WCNT_W  = $clog2(ALU_LAT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(ALU_LAT - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [WCNT_W-1:0]  r_wait_cnt;

    logic [CW-1:0]      w_head;
    logic [CW-1:0]      w_head_next;
    logic [CW-1:0]      w_cmd_load;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_more;
    logic               w_load;

    logic               r_on,        w_on_nxt;
    logic [2:0]         r_in_sel,    w_in_sel_nxt;
    logic [DW-1:0]      r_num1,      w_num1_nxt;
    logic [DW-1:0]      r_num2,      w_num2_nxt;
    logic [OPW-1:0]     r_out_sel,   w_out_sel_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic [DW-1:0]      r_res_data;
    logic [OPW-1:0]     r_res_op;
    logic               r_done,      w_done_nxt;
    logic               r_busy,      w_busy_nxt;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cmd_wr_en),
        .wr_data   (cmd_wr_data),
        .rd_en     (w_pop),
        .head      (w_head),
        .head_next (w_head_next),
        .full      (cmd_full),
        .empty     (w_empty),
        .count     (cmd_count),
        .ovf       (cmd_ovf)
    );

    assign w_pop     = (r_state == ST_HOLD) && res_ready;
    assign w_push_ok = cmd_wr_en && !cmd_full;
    // Work remains after this pop if another entry is queued or arriving now.
    assign w_more    = (cmd_count > CNT_W'(1)) || w_push_ok;

    // On a back-to-back issue the head is being popped, so take the entry
    // behind it, or the word being pushed when the buffer held only one.
    always_comb begin
        w_cmd_load = w_head;
        if (r_state == ST_HOLD) begin
            w_cmd_load = (cmd_count > CNT_W'(1)) ? w_head_next : cmd_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_empty) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = w_more ? ST_ISSUE : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        w_on_nxt     = 1'b0;
        w_in_sel_nxt = IN_SEL_IDLE;
        case (w_state_nxt)
            ST_ISSUE: begin
                w_on_nxt     = 1'b1;
                w_in_sel_nxt = IN_SEL_LOAD;
            end
            ST_WAIT: begin
                w_on_nxt     = 1'b1;
                w_in_sel_nxt = IN_SEL_PERSIST;
            end
            default: begin
                w_on_nxt     = 1'b0;
                w_in_sel_nxt = IN_SEL_IDLE;
            end
        endcase

        w_load        = (w_state_nxt == ST_ISSUE);
        w_num1_nxt    = w_load ? w_cmd_load[DW-1:0]         : r_num1;
        w_num2_nxt    = w_load ? w_cmd_load[N2_LSB +: DW]   : r_num2;
        w_out_sel_nxt = w_load ? w_cmd_load[OP_LSB +: OPW]  : r_out_sel;

        w_res_valid_nxt = r_res_valid;
        if (r_state == ST_CAPTURE) begin
            w_res_valid_nxt = 1'b1;
        end else if (w_pop) begin
            w_res_valid_nxt = 1'b0;
        end

        w_done_nxt = ((r_state == ST_IDLE) && start && w_empty) || (w_pop && !w_more);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_on        <= 1'b0;
            r_in_sel    <= IN_SEL_IDLE;
            r_num1      <= '0;
            r_num2      <= '0;
            r_out_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            r_on        <= w_on_nxt;
            r_in_sel    <= w_in_sel_nxt;
            r_num1      <= w_num1_nxt;
            r_num2      <= w_num2_nxt;
            r_out_sel   <= w_out_sel_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            if (r_state == ST_CAPTURE) begin
                r_res_data <= alu_out;
                r_res_op   <= r_out_sel;
            end
        end
    end

    assign on        = r_on;
    assign in_sel    = r_in_sel;
    assign num1      = r_num1;
    assign num2      = r_num2;
    assign out_sel   = r_out_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign done      = r_done;
    assign busy      = r_busy;

`ifdef RESULT_CHECK_EN
    logic [DW-1:0] r_expect;
    logic          r_err;
    logic [7:0]    r_mismatch_cnt;
    logic          w_miss;

    assign w_miss = (r_state == ST_CAPTURE) && (alu_out != r_expect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expect       <= '0;
            r_err          <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            if (w_load) begin
                r_expect <= w_cmd_load[EX_LSB +: DW];
            end
            r_err <= w_miss;
            if (w_miss && (r_mismatch_cnt != 8'hFF)) begin
                r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
            end
        end
    end

    assign err          = r_err;
    assign mismatch_cnt = r_mismatch_cnt;
`else
    logic w_unused_expect;
    assign w_unused_expect = ^w_cmd_load[EX_LSB +: DW];
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed self-checking bench with a stub ALU model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 8;
    localparam int ALU_LAT = 2;
    localparam int DW      = 8;
    localparam int OPW     = 7;
    localparam logic [6:0] OP_ADD = 7'b0001000;
    localparam logic [6:0] OP_SUB = 7'b0000001;
    localparam logic [6:0] OP_XOR = 7'b0000000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_wr_en;
    logic [3*DW+OPW-1:0]    cmd_wr_data;
    logic                   cmd_full;
    logic [$clog2(DEPTH):0] cmd_count;
    logic                   cmd_ovf;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   on;
    logic [2:0]             in_sel;
    logic [DW-1:0]          num1, num2;
    logic [OPW-1:0]         out_sel;
    logic [DW-1:0]          alu_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [DW-1:0]          res_data;
    logic [OPW-1:0]         res_op;
`ifdef RESULT_CHECK_EN
    logic                   err;
    logic [7:0]             mismatch_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .DW      (DW),
        .OPW     (OPW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_wr_en    (cmd_wr_en),
        .cmd_wr_data  (cmd_wr_data),
        .cmd_full     (cmd_full),
        .cmd_count    (cmd_count),
        .cmd_ovf      (cmd_ovf),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .on           (on),
        .in_sel       (in_sel),
        .num1         (num1),
        .num2         (num2),
        .out_sel      (out_sel),
        .alu_out      (alu_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_op       (res_op)
`ifdef RESULT_CHECK_EN
        ,.err          (err)
        ,.mismatch_cnt (mismatch_cnt)
`endif
    );

    // Stub ALU: latches a result on a load cycle, visible ALU_LAT cycles later.
    logic [DW-1:0] stub_pipe [ALU_LAT];

    function automatic logic [DW-1:0] stub_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
        if (op[3])      return a + b;
        else if (op[0]) return a - b;
        else            return a ^ b;
    endfunction

    always @(posedge clk) begin
        if (on && in_sel == 3'b010) stub_pipe[0] <= stub_f(num1, num2, out_sel);
        for (int i = 1; i < ALU_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign alu_out = stub_pipe[ALU_LAT-1];

    task automatic do_reset();
        rst = 1'b1; cmd_wr_en = 1'b0; start = 1'b0; res_ready = 1'b0; cmd_wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] n1, input logic [7:0] n2, input logic [6:0] op,
                        input logic [7:0] ex);
        cmd_wr_en   = 1'b1;
        cmd_wr_data = {ex, op, n2, n1};
        @(negedge clk);
        cmd_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({on, in_sel, busy, done, res_valid, cmd_ovf, cmd_full} !== 9'd0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 0", {on, in_sel, busy, done, res_valid, cmd_ovf, cmd_full});
        end
        tests_run++;
        if ({num1, num2, out_sel, res_data, res_op, cmd_count} !== '0) begin
            tests_failed++; $display("FAIL reset_data: num1=%h num2=%h op=%h rd=%h ro=%h cnt=%0d expected all 0", num1, num2, out_sel, res_data, res_op, cmd_count);
        end
`ifdef RESULT_CHECK_EN
        tests_run++;
        if ({err, mismatch_cnt} !== 9'd0) begin
            tests_failed++; $display("FAIL reset_chk: got err=%b cnt=%0d expected 0", err, mismatch_cnt);
        end
`endif
        // Reset in the middle of a run.
        push(8'h11, 8'h22, OP_ADD, 8'h33);
        push(8'h01, 8'h02, OP_ADD, 8'h03);
        res_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({on, in_sel, busy, res_valid, cmd_count} !== '0) begin
            tests_failed++; $display("FAIL midrun_reset: on=%b in_sel=%b busy=%b rv=%b cnt=%0d expected all 0", on, in_sel, busy, res_valid, cmd_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tests_run++;
            if (res_valid !== 1'b0 || in_sel !== 3'b000 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL abandoned_cmd: rv=%b in_sel=%b busy=%b expected 0/000/0", res_valid, in_sel, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(8'h57, 8'h1A, OP_ADD, 8'h71);
        res_ready = 1'b1;
        tests_run++;
        if (cmd_count !== 4'd1) begin
            tests_failed++; $display("FAIL single_count: got %0d expected 1", cmd_count);
        end
        pulse_start();
        tests_run++;
        if (in_sel !== 3'b010 || on !== 1'b1 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_issue: in_sel=%b on=%b busy=%b expected 010/1/1", in_sel, on, busy);
        end
        tests_run++;
        if ({num1, num2, out_sel} !== {8'h57, 8'h1A, OP_ADD}) begin
            tests_failed++; $display("FAIL single_operands: got %h %h %b expected 57 1a 0001000", num1, num2, out_sel);
        end
        for (int c = 0; c < ALU_LAT; c++) begin
            @(negedge clk);
            tests_run++;
            if (in_sel !== 3'b100 || on !== 1'b1) begin
                tests_failed++; $display("FAIL single_wait%0d: in_sel=%b on=%b expected 100/1", c, in_sel, on);
            end
        end
        @(negedge clk);
        tests_run++;
        if (in_sel !== 3'b000 || res_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_capture: in_sel=%b rv=%b expected 000/0", in_sel, res_valid);
        end
        @(negedge clk);
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 8'h71 || res_op !== OP_ADD || done !== 1'b0) begin
            tests_failed++; $display("FAIL single_result: rv=%b data=%h op=%b done=%b expected 1/71/0001000/0", res_valid, res_data, res_op, done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || cmd_count !== 4'd0) begin
            tests_failed++; $display("FAIL single_done: done=%b busy=%b rv=%b cnt=%0d expected 1/0/0/0", done, busy, res_valid, cmd_count);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || res_data !== 8'h71 || res_op !== OP_ADD) begin
            tests_failed++; $display("FAIL single_after: done=%b data=%h op=%b expected 0/71/0001000", done, res_data, res_op);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d  [3];
        logic [6:0] exp_op [3];
        int  k;
        bit  seen;
        exp_d  = '{8'h30, 8'h48, 8'hCC};
        exp_op = '{OP_ADD, OP_SUB, OP_XOR};
        do_reset();
        push(8'h10, 8'h20, OP_ADD, 8'h00);
        push(8'h50, 8'h08, OP_SUB, 8'h00);
        push(8'hF0, 8'h3C, OP_XOR, 8'h00);
        pulse_start();
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (res_valid) seen = 1; else @(negedge clk);
        end
        tests_run++;
        if (!seen || res_data !== 8'h30 || res_op !== OP_ADD) begin
            tests_failed++; $display("FAIL bp_first: seen=%0d data=%h op=%b expected 1/30/0001000", seen, res_data, res_op);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (res_valid !== 1'b1 || res_data !== 8'h30 || in_sel !== 3'b000) begin
                tests_failed++; $display("FAIL bp_hold%0d: rv=%b data=%h in_sel=%b expected 1/30/000", c, res_valid, res_data, in_sel);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_sel !== 3'b010 || num1 !== 8'h50) begin
            tests_failed++; $display("FAIL back_to_back: in_sel=%b num1=%h expected 010/50", in_sel, num1);
        end
        k = 1; seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid && k < 3) begin
                tests_run++;
                if (res_data !== exp_d[k] || res_op !== exp_op[k]) begin
                    tests_failed++; $display("FAIL bp_order%0d: data=%h op=%b expected %h/%b", k, res_data, res_op, exp_d[k], exp_op[k]);
                end
                k++;
            end
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (k !== 3 || !seen) begin
            tests_failed++; $display("FAIL bp_total: results=%0d done=%0d expected 3/1", k, seen);
        end
    endtask

    task automatic test_full_overflow();
        int k;
        bit seen;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) push(8'(i), 8'h01, OP_ADD, 8'h00);
        tests_run++;
        if (cmd_full !== 1'b1 || cmd_count !== 4'd8 || cmd_ovf !== 1'b1) begin
            tests_failed++; $display("FAIL full_flags: full=%b cnt=%0d ovf=%b expected 1/8/1", cmd_full, cmd_count, cmd_ovf);
        end
        res_ready = 1'b1;
        pulse_start();
        k = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (res_valid) begin
                tests_run++;
                if (res_data !== 8'(k + 1)) begin
                    tests_failed++; $display("FAIL full_order%0d: got %h expected %h", k, res_data, 8'(k + 1));
                end
                k++;
            end
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (k !== DEPTH || !seen || cmd_ovf !== 1'b1 || cmd_count !== 4'd0) begin
            tests_failed++; $display("FAIL full_drain: results=%0d done=%0d ovf=%b cnt=%0d expected 8/1/1/0", k, seen, cmd_ovf, cmd_count);
        end
        // Refill across the pointer wrap, half of it while the run is busy.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i), 8'h02, OP_ADD, 8'h00);
        pulse_start();
        for (int i = 4; i < DEPTH; i++) push(8'(8'h40 + i), 8'h02, OP_ADD, 8'h00);
        tests_run++;
        if (busy !== 1'b1 || cmd_count !== 4'd8 || cmd_full !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_fill: busy=%b cnt=%0d full=%b expected 1/8/1", busy, cmd_count, cmd_full);
        end
        res_ready = 1'b1;
        k = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (res_valid) begin
                tests_run++;
                if (res_data !== 8'(8'h42 + k)) begin
                    tests_failed++; $display("FAIL wrap_order%0d: got %h expected %h", k, res_data, 8'(8'h42 + k));
                end
                k++;
            end
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (k !== DEPTH || !seen) begin
            tests_failed++; $display("FAIL wrap_total: results=%0d done=%0d expected 8/1", k, seen);
        end
    endtask

    task automatic test_start_cases();
        int n_done;
        int n_res;
        do_reset();
        pulse_start();
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || in_sel !== 3'b000) begin
            tests_failed++; $display("FAIL empty_start: done=%b busy=%b in_sel=%b expected 1/0/000", done, busy, in_sel);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL empty_after: done=%b busy=%b expected 0/0", done, busy);
        end
        push(8'h05, 8'h03, OP_SUB, 8'h00);
        pulse_start();
        repeat (6) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || res_valid !== 1'b1) begin
            tests_failed++; $display("FAIL busy_hold: busy=%b rv=%b expected 1/1", busy, res_valid);
        end
        pulse_start();
        res_ready = 1'b1;
        n_done = 0; n_res = 0;
        for (int c = 0; c < 12; c++) begin
            if (res_valid) begin
                n_res++;
                tests_run++;
                if (res_data !== 8'h02) begin
                    tests_failed++; $display("FAIL busy_result: got %h expected 02", res_data);
                end
            end
            if (done) n_done++;
            @(negedge clk);
        end
        tests_run++;
        if (n_done !== 1 || n_res !== 1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL busy_start_ignored: dones=%0d results=%0d busy=%b expected 1/1/0", n_done, n_res, busy);
        end
    endtask

`ifdef RESULT_CHECK_EN
    task automatic test_result_check();
        int n_err;
        do_reset();
        res_ready = 1'b1;
        push(8'h57, 8'h19, OP_ADD, 8'h71);
        push(8'h57, 8'h1A, OP_ADD, 8'h71);
        pulse_start();
        n_err = 0;
        for (int c = 0; c < 40; c++) begin
            if (err) begin
                n_err++;
                tests_run++;
                if (res_valid !== 1'b1 || res_data !== 8'h70) begin
                    tests_failed++; $display("FAIL err_timing: rv=%b data=%h expected 1/70", res_valid, res_data);
                end
            end
            if (done) break;
            @(negedge clk);
        end
        tests_run++;
        if (n_err !== 1 || mismatch_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL err_count: pulses=%0d cnt=%0d expected 1/1", n_err, mismatch_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_wr_en = 1'b0; start = 1'b0; res_ready = 1'b0; cmd_wr_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_full_overflow();
        test_start_cases();
`ifdef RESULT_CHECK_EN
        test_result_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
